// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file, pending-write scoreboard and a
// one-entry output register with valid/ready handshakes on both sides.
module decode_issue_stage #(
   parameter int NREG = 32,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_dataa,
   output logic [XLEN-1:0] ex_datab,
   output logic [15:0]     ex_inst15_0,
   output logic [XLEN-1:0] ex_imm_ext,
   output logic [5:0]      ex_opcode,
   output logic [5:0]      ex_funct,
   output logic [4:0]      ex_shamt,
   output logic [4:0]      ex_dest,
   output logic            ex_illegal,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush
);

   typedef struct packed {
      logic [XLEN-1:0] dataa;
      logic [XLEN-1:0] datab;
      logic [15:0]     imm16;
      logic [XLEN-1:0] imm;
      logic [5:0]      op;
      logic [5:0]      funct;
      logic [4:0]      shamt;
      logic [4:0]      dest;
      logic            ill;
   } ex_t;

   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];
   logic [NREG-1:0] pend_q, pend_d;
   logic            ex_valid_q, ex_valid_d;
   ex_t             ex_q, ex_d, dec;

   logic [5:0] op;
   logic [4:0] rs, rt, rd;
   logic       is_r, is_ialu, is_lui, is_sb, is_zext;
   logic       use_rs, use_rt;
   logic [4:0] dest;
   logic       rs_busy, rt_busy, dst_busy, hazard, accept;

   assign op      = if_instr[31:26];
   assign rs      = if_instr[25:21];
   assign rt      = if_instr[20:16];
   assign rd      = if_instr[15:11];
   assign is_r    = (op == 6'h00);
   assign is_ialu = (op >= 6'h08 && op <= 6'h0E) || op == 6'h23;
   assign is_lui  = (op == 6'h0F);
   assign is_sb   = op == 6'h2B || op == 6'h04 || op == 6'h05;
   assign is_zext = (op >= 6'h0C && op <= 6'h0E);

   // Instruction class -> sources, destination, immediate and operands
   always_comb begin
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      dest    = 5'd0;
      dec     = '0;
      dec.ill = 1'b0;
      unique case (1'b1)
         is_r: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            dest   = rd;
         end
         is_ialu: begin
            use_rs = 1'b1;
            dest   = rt;
         end
         is_lui: dest = rt;
         is_sb: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
         end
         default: dec.ill = 1'b1;
      endcase
      unique case (1'b1)
         is_zext: dec.imm = {{(XLEN-16){1'b0}}, if_instr[15:0]};
         is_lui:  dec.imm = {if_instr[15:0], {(XLEN-16){1'b0}}};
         default: dec.imm = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
      endcase
      if (rs == 5'd0)
         dec.dataa = '0;
      else if (wb_en && wb_addr == rs)
         dec.dataa = wb_data;
      else
         dec.dataa = rf_q[rs];
      if (rt == 5'd0)
         dec.datab = '0;
      else if (wb_en && wb_addr == rt)
         dec.datab = wb_data;
      else
         dec.datab = rf_q[rt];
      dec.imm16 = if_instr[15:0];
      dec.op    = op;
      dec.funct = if_instr[5:0];
      dec.shamt = if_instr[10:6];
      dec.dest  = dest;
   end

   // Scoreboard hazards; a register being written back this cycle is free
   always_comb begin
      rs_busy  = use_rs && rs != 5'd0 && pend_q[rs]
                 && !(wb_en && wb_addr == rs);
      rt_busy  = use_rt && rt != 5'd0 && pend_q[rt]
                 && !(wb_en && wb_addr == rt);
      dst_busy = dest != 5'd0 && pend_q[dest]
                 && !(wb_en && wb_addr == dest);
      hazard   = rs_busy || rt_busy || dst_busy;
      if_ready = !flush && (!ex_valid_q || ex_ready) && !hazard;
      accept   = if_valid && if_ready;
   end

   // Pending bits: writeback and flush clear, issue sets (set wins)
   always_comb begin
      pend_d = pend_q;
      if (wb_en)
         pend_d[wb_addr] = 1'b0;
      if (flush && ex_valid_q)
         pend_d[ex_q.dest] = 1'b0;
      if (accept)
         pend_d[dest] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // Register file write port; register 0 stays zero
   always_comb begin
      for (int i = 0; i < NREG; i++)
         rf_d[i] = rf_q[i];
      if (wb_en && wb_addr != 5'd0)
         rf_d[wb_addr] = wb_data;
   end

   // Output register: load on accept, drop on consume or flush
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_d       = ex_q;
      if (accept) begin
         ex_valid_d = 1'b1;
         ex_d       = dec;
      end else if (flush || ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= '0;
      end else begin
         pend_q     <= pend_d;
         ex_valid_q <= ex_valid_d;
         ex_q       <= ex_d;
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= rf_d[i];
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_dataa    = ex_q.dataa;
   assign ex_datab    = ex_q.datab;
   assign ex_inst15_0 = ex_q.imm16;
   assign ex_imm_ext  = ex_q.imm;
   assign ex_opcode   = ex_q.op;
   assign ex_funct    = ex_q.funct;
   assign ex_shamt    = ex_q.shamt;
   assign ex_dest     = ex_q.dest;
   assign ex_illegal  = ex_q.ill;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: decode vector table, directed hazard,
// backpressure, flush and reset sequences, then random traffic vs a model.
module tb_decode_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_valid = 1'b0;
   logic        ex_ready = 1'b0;
   logic        wb_en = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] if_instr = '0;
   logic [31:0] wb_data = '0;
   logic [4:0]  wb_addr = '0;
   logic        if_ready, ex_valid, ex_illegal;
   logic [31:0] ex_dataa, ex_datab, ex_imm_ext;
   logic [15:0] ex_inst15_0;
   logic [5:0]  ex_opcode, ex_funct;
   logic [4:0]  ex_shamt, ex_dest;

   decode_issue_stage dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_dataa(ex_dataa), .ex_datab(ex_datab),
      .ex_inst15_0(ex_inst15_0), .ex_imm_ext(ex_imm_ext),
      .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
      .ex_dest(ex_dest), .ex_illegal(ex_illegal),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] a, b, imm;
      logic [15:0] i16;
      logic [5:0]  op, fn;
      logic [4:0]  sh, d;
      bit          ill, s1, s2;
   } mout_t;

   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          m_valid;
   mout_t       m_out;

   function automatic logic [31:0] m_rd(input int r);
      if (r == 0) return 32'd0;
      if (wb_en && int'(wb_addr) == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic bit m_busy(input int r);
      return r != 0 && m_pend[r] && !(wb_en && int'(wb_addr) == r);
   endfunction

   function automatic void m_dec(input logic [31:0] w, output mout_t o);
      int opc;
      opc = int'(w[31:26]);
      o = '{default: 0};
      if (opc == 0) begin
         o.s1 = 1; o.s2 = 1; o.d = w[15:11];
      end else if ((opc >= 8 && opc <= 14) || opc == 35) begin
         o.s1 = 1; o.d = w[20:16];
      end else if (opc == 15) begin
         o.d = w[20:16];
      end else if (opc == 43 || opc == 4 || opc == 5) begin
         o.s1 = 1; o.s2 = 1;
      end else begin
         o.ill = 1;
      end
      if (opc >= 12 && opc <= 14)
         o.imm = 32'(w[15:0]);
      else if (opc == 15)
         o.imm = 32'(w[15:0]) * 65536;
      else
         o.imm = w[15] ? 32'hFFFF0000 + 32'(w[15:0]) : 32'(w[15:0]);
      o.a   = m_rd(int'(w[25:21]));
      o.b   = m_rd(int'(w[20:16]));
      o.i16 = w[15:0];
      o.op  = w[31:26];
      o.fn  = w[5:0];
      o.sh  = w[10:6];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 0;
      end
      m_valid = 0;
      m_out   = '{default: 0};
   endtask

   // One clock: compare at negedge, advance model, return at posedge+1
   task automatic tick();
      mout_t nd;
      bit    haz, rdy, acc;
      @(negedge clk);
      m_dec(if_instr, nd);
      haz = (nd.s1 && m_busy(int'(if_instr[25:21])))
         || (nd.s2 && m_busy(int'(if_instr[20:16])))
         || m_busy(int'(nd.d));
      rdy = !flush && (!m_valid || ex_ready) && !haz;
      chk("if_ready", 32'(if_ready), 32'(rdy));
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      if (m_valid) begin
         if (m_out.s1) chk("ex_dataa", ex_dataa, m_out.a);
         if (m_out.s2) chk("ex_datab", ex_datab, m_out.b);
         chk("ex_inst15_0", 32'(ex_inst15_0), 32'(m_out.i16));
         chk("ex_imm_ext", ex_imm_ext, m_out.imm);
         chk("ex_opcode", 32'(ex_opcode), 32'(m_out.op));
         chk("ex_funct", 32'(ex_funct), 32'(m_out.fn));
         chk("ex_shamt", 32'(ex_shamt), 32'(m_out.sh));
         chk("ex_dest", 32'(ex_dest), 32'(m_out.d));
         chk("ex_illegal", 32'(ex_illegal), 32'(m_out.ill));
      end
      acc = if_valid && rdy;
      if (wb_en) m_pend[wb_addr] = 0;
      if (flush && m_valid) m_pend[m_out.d] = 0;
      if (acc) m_pend[nd.d] = 1;
      m_pend[0] = 0;
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (acc) begin
         m_valid = 1;
         m_out   = nd;
      end else if (flush || ex_ready) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] ins, input bit rdy,
                        input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input bit fl);
      if_valid = v;
      if_instr = ins;
      ex_ready = rdy;
      wb_en    = we;
      wb_addr  = wa;
      wb_data  = wd;
      flush    = fl;
   endtask

   task automatic do_reset();
      drive(0, '0, 0, 0, 5'd0, '0, 0);
      rst_n = 1'b0;
      m_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- decode vector table ----------------
   typedef struct {
      logic [31:0] ins;
      logic [4:0]  d;
      logic [31:0] imm;
      bit          ill;
   } vec_t;

   vec_t vt [13];

   function automatic logic [31:0] rnd_instr();
      logic [5:0] opc;
      int k;
      k = int'($urandom_range(0, 13));
      case (k)
         0:       opc = 6'h00;
         8:       opc = 6'h0F;
         9:       opc = 6'h23;
         10:      opc = 6'h2B;
         11:      opc = 6'h04;
         12:      opc = 6'h05;
         13:      opc = 6'h3F;
         default: opc = 6'(k + 7);
      endcase
      return {opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
   endfunction

   initial begin
      vt[0]  = '{32'h34A60F0F, 5'd6,  32'h00000F0F, 1'b0};
      vt[1]  = '{32'h2001FFFF, 5'd1,  32'hFFFFFFFF, 1'b0};
      vt[2]  = '{32'h3C021234, 5'd2,  32'h12340000, 1'b0};
      vt[3]  = '{32'hFC031234, 5'd0,  32'h00001234, 1'b1};
      vt[4]  = '{32'h30248000, 5'd4,  32'h00008000, 1'b0};
      vt[5]  = '{32'h3847FFFF, 5'd7,  32'h0000FFFF, 1'b0};
      vt[6]  = '{32'h00221820, 5'd3,  32'h00001820, 1'b0};
      vt[7]  = '{32'h8D09FFFC, 5'd9,  32'hFFFFFFFC, 1'b0};
      vt[8]  = '{32'hAD090008, 5'd0,  32'h00000008, 1'b0};
      vt[9]  = '{32'h1022FFFE, 5'd0,  32'hFFFFFFFE, 1'b0};
      vt[10] = '{32'h280A8001, 5'd10, 32'hFFFF8001, 1'b0};
      vt[11] = '{32'h08000010, 5'd0,  32'h00000010, 1'b1};
      vt[12] = '{32'h00000000, 5'd0,  32'h00000000, 1'b0};

      // Reset state and first issue with an operand from writeback
      do_reset();
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_dataa", ex_dataa, 32'd0);
      chk("rst_ex_imm", ex_imm_ext, 32'd0);
      chk("rst_ex_dest", 32'(ex_dest), 32'd0);
      chk("rst_ex_ill", 32'(ex_illegal), 32'd0);
      drive(0, '0, 1, 1, 5'd5, 32'h0000F0F0, 0);
      tick();
      drive(1, 32'h34A60F0F, 1, 0, 5'd0, '0, 0);
      tick();
      chk("ori_valid", 32'(ex_valid), 32'd1);
      chk("ori_dataa", ex_dataa, 32'h0000F0F0);
      chk("ori_imm", ex_imm_ext, 32'h00000F0F);
      chk("ori_dest", 32'(ex_dest), 32'd6);
      drive(1, 32'h00C04020, 1, 0, 5'd0, '0, 0);
      #1;
      chk("pend6_stall", 32'(if_ready), 32'd0);
      tick();

      // Decode table, clearing the destination after each entry
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(1, vt[i].ins, 1, 0, 5'd0, '0, 0);
         tick();
         chk("vec_valid", 32'(ex_valid), 32'd1);
         chk("vec_dest", 32'(ex_dest), 32'(vt[i].d));
         chk("vec_imm", ex_imm_ext, vt[i].imm);
         chk("vec_ill", 32'(ex_illegal), 32'(vt[i].ill));
         drive(0, '0, 1, 1, vt[i].d, '0, 0);
         tick();
      end

      // RAW stall released by writeback with bypass
      do_reset();
      drive(1, 32'h00221820, 1, 0, 5'd0, '0, 0);
      tick();
      drive(1, 32'h00632025, 1, 0, 5'd0, '0, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("raw_stall", 32'(if_ready), 32'd0);
         tick();
      end
      drive(1, 32'h00632025, 1, 1, 5'd3, 32'hAAAA5555, 0);
      #1;
      chk("raw_release", 32'(if_ready), 32'd1);
      tick();
      chk("raw_valid", 32'(ex_valid), 32'd1);
      chk("raw_dataa", ex_dataa, 32'hAAAA5555);
      chk("raw_datab", ex_datab, 32'hAAAA5555);
      chk("raw_dest", 32'(ex_dest), 32'd4);

      // Backpressure holds outputs, then back-to-back issue
      drive(1, 32'h340A0001, 0, 0, 5'd0, '0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_dest", 32'(ex_dest), 32'd4);
         chk("bp_dataa", ex_dataa, 32'hAAAA5555);
         chk("bp_ready", 32'(if_ready), 32'd0);
      end
      drive(1, 32'h340A0001, 1, 0, 5'd0, '0, 0);
      #1;
      chk("bp_release", 32'(if_ready), 32'd1);
      tick();
      chk("b2b_valid0", 32'(ex_valid), 32'd1);
      chk("b2b_dest0", 32'(ex_dest), 32'd10);
      drive(1, 32'h340B0002, 1, 0, 5'd0, '0, 0);
      tick();
      chk("b2b_valid1", 32'(ex_valid), 32'd1);
      chk("b2b_dest1", 32'(ex_dest), 32'd11);
      drive(0, '0, 1, 0, 5'd0, '0, 0);
      tick();
      chk("drain_valid", 32'(ex_valid), 32'd0);

      // Flush discards the entry and its pending bit
      do_reset();
      drive(1, 32'h34070005, 1, 0, 5'd0, '0, 0);
      tick();
      chk("fl_dest", 32'(ex_dest), 32'd7);
      drive(1, 32'h00E06025, 0, 0, 5'd0, '0, 1);
      #1;
      chk("fl_ready", 32'(if_ready), 32'd0);
      tick();
      chk("fl_valid", 32'(ex_valid), 32'd0);
      chk("fl_pend7", 32'(dut.pend_q[7]), 32'd0);
      drive(1, 32'h00E06025, 1, 0, 5'd0, '0, 0);
      #1;
      chk("fl_noreuse_stall", 32'(if_ready), 32'd1);
      tick();
      chk("fl_issue_dest", 32'(ex_dest), 32'd12);

      // Async reset mid-stall, then writeback after reset
      do_reset();
      drive(1, 32'h34070005, 1, 0, 5'd0, '0, 0);
      tick();
      drive(1, 32'h00E06025, 0, 0, 5'd0, '0, 0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(ex_valid), 32'd0);
      chk("arst_pend", dut.pend_q, 32'd0);
      chk("arst_dest", 32'(ex_dest), 32'd0);
      m_reset();
      drive(0, '0, 0, 0, 5'd0, '0, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(0, '0, 1, 1, 5'd5, 32'h00001234, 0);
      tick();
      drive(1, 32'h34A60000, 1, 0, 5'd0, '0, 0);
      tick();
      chk("post_rst_dataa", ex_dataa, 32'h00001234);

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic        we;
         logic [4:0]  wa;
         we = ($urandom_range(0, 2) == 0);
         wa = 5'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0, rnd_instr(),
               $urandom_range(0, 3) != 0, we, wa, $urandom,
               $urandom_range(0, 15) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
